// File: rtl/mc_defs_pkg.sv
// Shared encodings for the multicycle CPU control unit: state codes, opcodes,
// ALU function codes and the opcode-class / next-state helpers.
package mc_defs_pkg;

    localparam int OPC_W = 6;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } mc_state_e;

    typedef enum logic [2:0] {
        CL_NOP,
        CL_RALU,
        CL_IALU,
        CL_LW,
        CL_SW,
        CL_BR,
        CL_JMP,
        CL_HALT
    } op_class_e;

    localparam logic [OPC_W-1:0] OP_ADD   = 6'b000000;
    localparam logic [OPC_W-1:0] OP_SUB   = 6'b000001;
    localparam logic [OPC_W-1:0] OP_AND   = 6'b010001;
    localparam logic [OPC_W-1:0] OP_OR    = 6'b010000;
    localparam logic [OPC_W-1:0] OP_SLL   = 6'b011000;
    localparam logic [OPC_W-1:0] OP_SLT   = 6'b100110;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b000010;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'b010010;
    localparam logic [OPC_W-1:0] OP_SLTIU = 6'b100111;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b110000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b110001;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b110100;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'b110101;
    localparam logic [OPC_W-1:0] OP_BLTZ  = 6'b110110;
    localparam logic [OPC_W-1:0] OP_J     = 6'b111000;
    localparam logic [OPC_W-1:0] OP_JR    = 6'b111001;
    localparam logic [OPC_W-1:0] OP_JAL   = 6'b111010;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLTU = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;
    localparam logic [2:0] ALU_SLL  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_AND  = 3'b110;

    // The halt opcode is checked first so an overridden HALT_OP always wins.
    function automatic op_class_e op_class(input logic [OPC_W-1:0] op,
                                           input logic [OPC_W-1:0] halt_op);
        op_class_e c;
        c = CL_NOP;
        if (op == halt_op) begin
            c = CL_HALT;
        end else begin
            case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SLT: c = CL_RALU;
                OP_ADDI, OP_ORI, OP_SLTIU:                     c = CL_IALU;
                OP_LW:                                         c = CL_LW;
                OP_SW:                                         c = CL_SW;
                OP_BEQ, OP_BNE, OP_BLTZ:                       c = CL_BR;
                OP_J, OP_JR, OP_JAL:                           c = CL_JMP;
                default:                                       c = CL_NOP;
            endcase
        end
        return c;
    endfunction

    function automatic logic [2:0] alu_op_of(input logic [OPC_W-1:0] op);
        logic [2:0] a;
        a = ALU_ADD;
        case (op)
            OP_SUB, OP_BEQ, OP_BNE: a = ALU_SUB;
            OP_AND:                 a = ALU_AND;
            OP_OR, OP_ORI:          a = ALU_OR;
            OP_SLL:                 a = ALU_SLL;
            OP_SLT:                 a = ALU_SLT;
            OP_SLTIU:               a = ALU_SLTU;
            default:                a = ALU_ADD;
        endcase
        return a;
    endfunction

    function automatic mc_state_e next_state_of(input mc_state_e st,
                                                input op_class_e cls,
                                                input logic halted);
        mc_state_e ns;
        ns = S_IF;
        case (st)
            S_IF: ns = S_ID;
            S_ID: begin
                if (halted)                               ns = S_IF;
                else if (cls == CL_RALU || cls == CL_IALU) ns = S_EXE_AL;
                else if (cls == CL_LW || cls == CL_SW)     ns = S_EXE_LS;
                else if (cls == CL_BR)                     ns = S_EXE_BR;
                else                                       ns = S_IF;
            end
            S_EXE_AL: ns = S_WB_AL;
            S_EXE_LS: ns = S_MEM;
            S_MEM:    ns = (cls == CL_LW) ? S_WB_LD : S_IF;
            default:  ns = S_IF;
        endcase
        return ns;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational strobe decode: maps the (possibly reset-overridden) state,
// opcode and ALU flags to the per-cycle datapath controls.
module mc_ctrl_decode
    import mc_defs_pkg::*;
#(
    parameter logic [OPC_W-1:0] HALT_OP = 6'b111111
) (
    input  mc_state_e         state,
    input  logic [OPC_W-1:0]  opcode,
    input  logic              zero,
    input  logic              sign,
    input  logic              halted,
    input  logic              last_cycle,
    output logic              PCWre,
    output logic              IRWre,
    output logic              RegWre,
    output logic              mRD,
    output logic              mWR,
    output logic              ALUSrcA,
    output logic              ALUSrcB,
    output logic              ExtSel,
    output logic [1:0]        RegDst,
    output logic              WrRegDSrc,
    output logic              DBDataSrc,
    output logic [1:0]        PCSrc,
    output logic [2:0]        ALUOp
);

    op_class_e cls;
    logic      br_taken;
    logic      is_jal;

    always_comb begin
        cls      = op_class(opcode, HALT_OP);
        is_jal   = (cls == CL_JMP) && (opcode == OP_JAL);
        br_taken = 1'b0;
        case (opcode)
            OP_BEQ:  br_taken = zero;
            OP_BNE:  br_taken = ~zero;
            OP_BLTZ: br_taken = sign;
            default: br_taken = 1'b0;
        endcase

        PCWre     = last_cycle && !halted && (cls != CL_HALT);
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        PCSrc     = 2'b00;
        ALUSrcA   = (opcode == OP_SLL);
        ALUSrcB   = (cls == CL_IALU) || (cls == CL_LW) || (cls == CL_SW);
        ExtSel    = (opcode == OP_ADDI) || (opcode == OP_SLTIU) || (cls == CL_LW) ||
                    (cls == CL_SW) || (cls == CL_BR);
        RegDst    = is_jal ? 2'b00 : ((cls == CL_RALU) ? 2'b10 : 2'b01);
        WrRegDSrc = ~is_jal;
        DBDataSrc = (cls == CL_LW);
        ALUOp     = alu_op_of(opcode);

        case (state)
            S_IF: IRWre = ~halted;
            S_ID: begin
                RegWre = is_jal && !halted;
                if (cls == CL_JMP) begin
                    PCSrc = (opcode == OP_JR) ? 2'b10 : 2'b11;
                end
            end
            S_EXE_BR: PCSrc = br_taken ? 2'b01 : 2'b00;
            S_MEM: begin
                mWR = (cls == CL_SW) && !halted;
                mRD = (cls == CL_LW) && !halted;
            end
            S_WB_AL, S_WB_LD: RegWre = ~halted;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle CPU control unit: state register, sticky halt flag and
// next-state logic; strobes come from mc_ctrl_decode.
module mc_control_fsm
    import mc_defs_pkg::*;
#(
    parameter int             OPW     = 6,
    parameter logic [OPW-1:0] HALT_OP = 6'b111111
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           sign,
    output logic [2:0]     state,
    output logic [2:0]     next_state,
    output logic           PCWre,
    output logic           IRWre,
    output logic           RegWre,
    output logic           mRD,
    output logic           mWR,
    output logic           ALUSrcA,
    output logic           ALUSrcB,
    output logic           ExtSel,
    output logic [1:0]     RegDst,
    output logic           WrRegDSrc,
    output logic           DBDataSrc,
    output logic [1:0]     PCSrc,
    output logic [2:0]     ALUOp,
    output logic           halted
);

    localparam logic [OPC_W-1:0] HALT6 = OPC_W'(HALT_OP);

    mc_state_e        cur_state;
    mc_state_e        dec_state;
    mc_state_e        ns_dec;
    mc_state_e        nxt;
    logic             halted_q;
    logic             dec_halted;
    logic [OPC_W-1:0] op6;
    op_class_e        cls;

    assign op6 = OPC_W'(opcode);

    // While RST is high the outputs look like a clean IF cycle, so an
    // abandoned instruction never leaks a write strobe in its reset cycle.
    always_comb begin
        cls        = op_class(op6, HALT6);
        dec_state  = RST ? S_IF : cur_state;
        dec_halted = RST ? 1'b0 : halted_q;
        ns_dec     = next_state_of(dec_state, cls, dec_halted);
        nxt        = RST ? S_IF : ns_dec;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cur_state <= S_IF;
            halted_q  <= 1'b0;
        end else begin
            cur_state <= nxt;
            if (cur_state == S_ID && cls == CL_HALT) halted_q <= 1'b1;
        end
    end

    assign state      = cur_state;
    assign next_state = nxt;
    assign halted     = halted_q;

    mc_ctrl_decode #(.HALT_OP(HALT6)) u_decode (
        .state      (dec_state),
        .opcode     (op6),
        .zero       (zero),
        .sign       (sign),
        .halted     (dec_halted),
        .last_cycle (ns_dec == S_IF),
        .PCWre      (PCWre),
        .IRWre      (IRWre),
        .RegWre     (RegWre),
        .mRD        (mRD),
        .mWR        (mWR),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ExtSel     (ExtSel),
        .RegDst     (RegDst),
        .WrRegDSrc  (WrRegDSrc),
        .DBDataSrc  (DBDataSrc),
        .PCSrc      (PCSrc),
        .ALUOp      (ALUOp)
    );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instruction-level reference model pushes one
// expected control record per cycle; a negedge monitor pops and compares.
module tb_mc_control_fsm;

    localparam int W = 24;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] ns;
        logic       pcwre;
        logic       irwre;
        logic       regwre;
        logic       mrd;
        logic       mwr;
        logic [1:0] pcsrc;
        logic [1:0] regdst;
        logic       wrregdsrc;
        logic       dbdatasrc;
        logic [2:0] aluop;
        logic       alusrca;
        logic       alusrcb;
        logic       extsel;
        logic       hlt;
    } rec_t;

    localparam logic [2:0] T_IF = 3'b000, T_ID = 3'b001, T_EAL = 3'b110, T_WAL = 3'b111,
                           T_EBR = 3'b101, T_ELS = 3'b010, T_MEM = 3'b011, T_WLD = 3'b100;

    localparam int K_NOP = 0, K_R = 1, K_I = 2, K_LW = 3, K_SW = 4, K_BR = 5, K_J = 6, K_H = 7;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] opcode = 6'b0;
    logic       zero = 1'b0;
    logic       sign = 1'b0;
    logic [2:0] state, next_state, ALUOp;
    logic       PCWre, IRWre, RegWre, mRD, mWR, ALUSrcA, ALUSrcB, ExtSel;
    logic       WrRegDSrc, DBDataSrc, halted;
    logic [1:0] RegDst, PCSrc;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] msk_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0] op_tab [0:19] = '{6'b000000, 6'b000001, 6'b010001, 6'b010000, 6'b011000,
                                  6'b100110, 6'b000010, 6'b010010, 6'b100111, 6'b110000,
                                  6'b110001, 6'b110100, 6'b110101, 6'b110110, 6'b111000,
                                  6'b111001, 6'b111010, 6'b000011, 6'b101010, 6'b011111};

    always #5 CLK = ~CLK;

    mc_control_fsm dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero), .sign(sign),
        .state(state), .next_state(next_state), .PCWre(PCWre), .IRWre(IRWre),
        .RegWre(RegWre), .mRD(mRD), .mWR(mWR), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ExtSel(ExtSel), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
        .PCSrc(PCSrc), .ALUOp(ALUOp), .halted(halted)
    );

    // ---------------- reference model ----------------
    function automatic int kind_of(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000001, 6'b010001, 6'b010000, 6'b011000, 6'b100110: return K_R;
            6'b000010, 6'b010010, 6'b100111: return K_I;
            6'b110001: return K_LW;
            6'b110000: return K_SW;
            6'b110100, 6'b110101, 6'b110110: return K_BR;
            6'b111000, 6'b111001, 6'b111010: return K_J;
            6'b111111: return K_H;
            default: return K_NOP;
        endcase
    endfunction

    function automatic logic [2:0] ref_aluop(input logic [5:0] op);
        case (op)
            6'b000001: return 3'b001;
            6'b010001: return 3'b110;
            6'b010000, 6'b010010: return 3'b101;
            6'b011000: return 3'b100;
            6'b100110: return 3'b011;
            6'b100111: return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic rec_t base_mask();
        rec_t m;
        m = '0;
        m.st = '1; m.ns = '1; m.pcwre = 1; m.irwre = 1; m.regwre = 1;
        m.mrd = 1; m.mwr = 1; m.pcsrc = '1; m.hlt = 1;
        return m;
    endfunction

    task automatic push_rec(input rec_t r, input rec_t m);
        exp_q.push_back(W'(r));
        msk_q.push_back(W'(m));
    endtask

    // Pushes the expected per-cycle records of one instruction (up to max_cyc
    // of them) and returns the instruction's full latency.
    task automatic model_instr(input logic [5:0] op, input logic z, input logic s,
                               input int max_cyc, output int len);
        logic [2:0] path [0:4];
        int   k;
        logic taken;
        rec_t r, m;
        k = kind_of(op);
        path[0] = T_IF; path[1] = T_ID; path[2] = T_IF; path[3] = T_IF; path[4] = T_IF;
        len = 2;
        if (k == K_R || k == K_I) begin path[2] = T_EAL; path[3] = T_WAL; len = 4; end
        if (k == K_LW) begin path[2] = T_ELS; path[3] = T_MEM; path[4] = T_WLD; len = 5; end
        if (k == K_SW) begin path[2] = T_ELS; path[3] = T_MEM; len = 4; end
        if (k == K_BR) begin path[2] = T_EBR; len = 3; end
        taken = (op == 6'b110100) ? z : (op == 6'b110101) ? ~z : s;
        for (int i = 0; i < len && i < max_cyc; i++) begin
            r = '0;
            m = base_mask();
            r.st     = path[i];
            r.ns     = (i == len - 1) ? T_IF : path[i + 1];
            r.pcwre  = (i == len - 1) && (k != K_H);
            r.irwre  = (path[i] == T_IF);
            r.regwre = (path[i] == T_WAL) || (path[i] == T_WLD) ||
                       (path[i] == T_ID && op == 6'b111010);
            r.mrd    = (path[i] == T_MEM) && (k == K_LW);
            r.mwr    = (path[i] == T_MEM) && (k == K_SW);
            if (path[i] == T_ID && k == K_J) r.pcsrc = (op == 6'b111001) ? 2'b10 : 2'b11;
            if (path[i] == T_EBR && taken) r.pcsrc = 2'b01;
            if (r.regwre) begin
                r.regdst    = (op == 6'b111010) ? 2'b00 : (k == K_R) ? 2'b10 : 2'b01;
                r.wrregdsrc = (op != 6'b111010);
                r.dbdatasrc = (k == K_LW);
                m.regdst = '1; m.wrregdsrc = 1; m.dbdatasrc = 1;
            end
            if (path[i] == T_EAL || path[i] == T_ELS) begin
                r.aluop   = ref_aluop(op);
                r.alusrca = (op == 6'b011000);
                r.alusrcb = (k != K_R);
                r.extsel  = (op != 6'b010010);
                m.aluop = '1; m.alusrca = 1; m.alusrcb = 1;
                m.extsel = (k != K_R);
            end
            push_rec(r, m);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic issue(input logic [5:0] op, input logic z, input logic s);
        int len;
        model_instr(op, z, s, 5, len);
        opcode = op; zero = z; sign = s;
        repeat (len) @(posedge CLK);
        #1;
    endtask

    task automatic issue_random();
        issue(op_tab[$urandom_range(0, 19)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic reset_mid_lw();
        int   len;
        rec_t r, m;
        model_instr(6'b110001, 1'b0, 1'b0, 3, len);
        r = '0; m = base_mask();
        r.st = T_MEM; r.ns = T_IF; r.irwre = 1'b1;
        push_rec(r, m);
        opcode = 6'b110001; zero = 1'b0; sign = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic halt_run();
        int   len;
        rec_t r, m;
        issue(6'b111111, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            r = '0; m = base_mask();
            r.st  = (i % 2 == 0) ? T_IF : T_ID;
            r.ns  = (i % 2 == 0) ? T_ID : T_IF;
            r.hlt = 1'b1;
            push_rec(r, m);
        end
        len = 20;
        repeat (len) @(posedge CLK);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        if (exp_q.size() != 0) begin
            rec_t got;
            logic [W-1:0] e, mk;
            e  = exp_q.pop_front();
            mk = msk_q.pop_front();
            got.st = state; got.ns = next_state; got.pcwre = PCWre; got.irwre = IRWre;
            got.regwre = RegWre; got.mrd = mRD; got.mwr = mWR; got.pcsrc = PCSrc;
            got.regdst = RegDst; got.wrregdsrc = WrRegDSrc; got.dbdatasrc = DBDataSrc;
            got.aluop = ALUOp; got.alusrca = ALUSrcA; got.alusrcb = ALUSrcB;
            got.extsel = ExtSel; got.hlt = halted;
            n_checks++;
            if (((W'(got) ^ e) & mk) != '0) begin
                n_fail++;
                $display("FAIL ctrl_cycle t=%0t op=%b got=%h expected=%h mask=%h",
                         $time, opcode, W'(got) & mk, e & mk, mk);
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        do_reset();
        issue(6'b000000, 1'b0, 1'b0);
        issue(6'b110001, 1'b0, 1'b0);
        issue(6'b110000, 1'b0, 1'b0);
        issue(6'b110100, 1'b1, 1'b0);
        issue(6'b110100, 1'b0, 1'b0);
        issue(6'b110101, 1'b0, 1'b0);
        issue(6'b110101, 1'b1, 1'b0);
        issue(6'b110110, 1'b0, 1'b1);
        issue(6'b110110, 1'b1, 1'b0);
        issue(6'b111010, 1'b0, 1'b0);
        issue(6'b111000, 1'b0, 1'b0);
        issue(6'b111001, 1'b0, 1'b0);
        issue(6'b000011, 1'b0, 1'b0);
        issue(6'b010010, 1'b0, 1'b0);
        issue(6'b011000, 1'b0, 1'b0);
        issue(6'b100111, 1'b0, 1'b0);
        for (int i = 0; i < 80; i++) issue_random();
        reset_mid_lw();
        for (int i = 0; i < 10; i++) issue_random();
        halt_run();
        do_reset();
        issue(6'b000000, 1'b0, 1'b0);
        issue(6'b110001, 1'b0, 1'b0);
        reset_mid_lw();
        issue(6'b110000, 1'b0, 1'b0);
        @(negedge CLK);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain left=%0d expected=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
